// File: rtl/load_unit.sv
// RV32I load memory-access stage: effective-address generation, alignment checks,
// a single outstanding word read over valid/ready, and lane extraction to writeback.

package load_pkg;

  typedef enum logic [2:0] {
    lk_lb      = 3'd0,
    lk_lh      = 3'd1,
    lk_lw      = 3'd2,
    lk_lbu     = 3'd3,
    lk_lhu     = 3'd4,
    lk_invalid = 3'd7
  } load_kind_t;

  typedef enum logic [1:0] {
    cause_none       = 2'd0,
    cause_misaligned = 2'd1,
    cause_illegal    = 2'd2,
    cause_timeout    = 2'd3
  } cause_t;

endpackage

module load_unit
  import load_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  load_kind_t  kind,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [4:0]  rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_fault,
  output logic [1:0]  wb_cause,
  output logic [31:0] wb_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        armed;
  logic [15:0] timer;
  load_kind_t  kind_q;
  logic [4:0]  rd_q;
  logic [31:0] ea_q;
  logic [31:0] data_q;
  logic        fault_q;
  cause_t      cause_q;

  logic [31:0] ea_in;
  logic        accept;
  logic        timeout_hit;
  cause_t      accept_cause;

  // Lane select and extension of the addressed byte/halfword within the read word.
  function automatic logic [31:0] extract(input load_kind_t k, input logic [1:0] lane,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (k)
      lk_lb:   return {{24{b[7]}}, b};
      lk_lbu:  return {24'd0, b};
      lk_lh:   return {{16{h[15]}}, h};
      lk_lhu:  return {16'd0, h};
      lk_lw:   return word;
      default: return 32'd0;
    endcase
  endfunction

  assign ea_in       = base + offset;
  assign accept      = (state == IDLE) && armed && in_valid;
  assign timeout_hit = (timer == 16'(TIMEOUT - 1));

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    accept_cause = cause_none;
    case (kind)
      lk_lb, lk_lbu: accept_cause = cause_none;
      lk_lh, lk_lhu: if (ea_in[0])           accept_cause = cause_misaligned;
      lk_lw:         if (ea_in[1:0] != 2'b0) accept_cause = cause_misaligned;
      default:       accept_cause = cause_illegal;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (accept_cause != cause_none) ? RESP : REQ;
      REQ:  if (mem_req_ready) state_next = WAIT;
      WAIT: if (mem_rsp_valid || timeout_hit) state_next = RESP;
      RESP: if (wb_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      armed   <= 1'b0;
      timer   <= '0;
      kind_q  <= lk_lb;
      rd_q    <= '0;
      ea_q    <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
      cause_q <= cause_none;
    end else begin
      // Holds in_ready low for the first cycle after reset releases.
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            kind_q  <= kind;
            rd_q    <= rd;
            ea_q    <= ea_in;
            data_q  <= '0;
            fault_q <= (accept_cause != cause_none);
            cause_q <= accept_cause;
          end
        end
        REQ: begin
          if (mem_req_ready) timer <= '0;
        end
        WAIT: begin
          timer <= timer + 16'd1;
          // A response in the last allowed cycle still beats the timeout.
          if (mem_rsp_valid) begin
            data_q <= extract(kind_q, ea_q[1:0], mem_rsp_data);
          end else if (timeout_hit) begin
            fault_q <= 1'b1;
            cause_q <= cause_timeout;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (state == IDLE) && armed;
  assign mem_req_valid = (state == REQ);
  assign mem_addr      = {ea_q[31:2], 2'b00};
  assign wb_valid      = (state == RESP);
  assign wb_rd         = rd_q;
  assign wb_data       = data_q;
  assign wb_fault      = fault_q;
  assign wb_cause      = cause_q;
  assign wb_addr       = ea_q;

endmodule
